// File: rtl/bram_flex_stream_writer.sv
// bram_flex_stream_writer: stream or fill write sequencer over a wrapping BRAM address window
module bram_flex_stream_writer #(
  parameter int DEPTH = 5130,
  parameter int BITS_D = 20,
  parameter int FILL_VALUE = 10,
  localparam int BITS_A = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start_i,
  input  logic              fill_i,
  input  logic [BITS_A-1:0] start_addr_i,
  input  logic [BITS_A:0]   length_i,
  input  logic              s_valid_i,
  input  logic [BITS_D-1:0] s_data_i,
  output logic              s_ready_o,
  output logic [BITS_A-1:0] mem_addr_o,
  output logic              mem_wen_o,
  output logic [BITS_D-1:0] mem_wdata_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);
  localparam logic [BITS_A-1:0] LAST_A = BITS_A'(DEPTH - 1);
  localparam logic [BITS_A:0] DEPTH_L = (BITS_A + 1)'(DEPTH);
  typedef enum logic [1:0] {IDLE, STREAM, FILL, DONE} state_t;
  state_t state_q;
  logic [BITS_A-1:0] addr_q;
  logic [BITS_A:0] rem_q;
  logic [BITS_A-1:0] addr_d;
  logic hs, last, wr;
  assign addr_d = (addr_q == LAST_A) ? '0 : addr_q + 1'b1;
  assign hs = s_valid_i && s_ready_o;
  assign last = rem_q == (BITS_A + 1)'(1);
  assign wr = (state_q == STREAM && hs) || state_q == FILL;
  // Command FSM; every output is registered and the strobes default low each cycle
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      addr_q <= '0;
      rem_q <= '0;
      s_ready_o <= 1'b0;
      mem_addr_o <= '0;
      mem_wen_o <= 1'b0;
      mem_wdata_o <= '0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
      err_o <= 1'b0;
    end else begin
      mem_wen_o <= 1'b0;
      done_o <= 1'b0;
      err_o <= 1'b0;
      case (state_q)
        IDLE: if (start_i) begin
          addr_q <= start_addr_i;
          rem_q <= length_i;
          if ({1'b0, start_addr_i} >= DEPTH_L || length_i > DEPTH_L) err_o <= 1'b1;
          else if (length_i == '0) begin
            state_q <= DONE;
            done_o <= 1'b1;
          end else begin
            state_q <= fill_i ? FILL : STREAM;
            s_ready_o <= !fill_i;
            busy_o <= 1'b1;
          end
        end
        STREAM, FILL: if (wr) begin
          mem_wen_o <= 1'b1;
          mem_addr_o <= addr_q;
          mem_wdata_o <= (state_q == FILL) ? BITS_D'(FILL_VALUE) : s_data_i;
          addr_q <= addr_d;
          rem_q <= rem_q - 1'b1;
          if (last) begin
            state_q <= DONE;
            s_ready_o <= 1'b0;
            busy_o <= 1'b0;
            done_o <= 1'b1;
          end
        end
        DONE: state_q <= IDLE;
      endcase
    end
  end
endmodule
